// File: rtl/lab1_random_top.sv
// lab1_random_top: core of the lab-1 random-number game.
// A start pulse launches a shuffle. The displayed nibble is reloaded from a
// free-running LFSR at ever longer intervals until it settles. Each settled
// value is logged in a 16-deep circular history that left/right pulses browse
// while idle. All outputs come straight from flops.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | showing the history entry selected by index; browsing allowed
//   RUN   | shuffling; the value is reloaded at the end of each step

module lab1_random_top #(
    parameter int BASE_PERIOD = 500000,
    parameter int SHUF_STEPS  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_left,
    input  logic        i_right,
    output logic [3:0]  o_random_out,
    output logic [3:0]  o_index_out,
    output logic [17:0] o_led,
    output logic [8:0]  o_led_idx
);

    // Wide enough for the period after the final step, which is discarded.
    localparam int TW = $clog2(BASE_PERIOD * (SHUF_STEPS + 1) + 1);
    localparam int SW = $clog2(SHUF_STEPS + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [15:0]   LFSR_SEED = 16'hACE1;
    localparam logic [TW-1:0] BASE_W    = TW'(BASE_PERIOD);
    localparam logic [SW-1:0] LAST_STEP = SW'(SHUF_STEPS - 1);
    localparam logic [4:0]    HIST_FULL = 5'd16;

    logic [0:0]    state, state_nxt;
    logic [15:0]   lfsr, lfsr_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [TW-1:0] period, period_nxt;
    logic [SW-1:0] step, step_nxt;
    logic [3:0]    hist [16];
    logic [3:0]    wptr, wptr_nxt;
    logic [4:0]    count, count_nxt;
    logic [3:0]    index, index_nxt;
    logic [3:0]    rnd_nxt;
    logic [3:0]    rd_ptr;
    logic          hist_we;
    logic          step_done;
    logic          browse_left;
    logic          browse_right;
    logic [15:0]   onehot_nxt;

    assign o_index_out = index;

    // Fibonacci LFSR, taps 16,14,13,11; free-runs so results depend on press timing.
    always_comb begin
        lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Browse decode: opposing pulses in the same cycle cancel, and an empty
    // history has nothing to browse.
    always_comb begin
        browse_left  = i_left && !i_right && (count != 5'd0)
                       && ({1'b0, index} < (count - 5'd1));
        browse_right = i_right && !i_left && (count != 5'd0)
                       && (index != 4'd0);
    end

    // Next-state logic for the shuffle sequencer, history pointers and display.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        period_nxt = period;
        step_nxt   = step;
        wptr_nxt   = wptr;
        count_nxt  = count;
        index_nxt  = index;
        rnd_nxt    = o_random_out;
        hist_we    = 1'b0;
        rd_ptr     = wptr - 4'd1 - index;
        step_done  = (timer == (period - TW'(1)));

        case (state)
            ST_IDLE: begin
                // Display follows the registered index, so it lags an index
                // change by one cycle. An empty history keeps showing 0.
                if (count != 5'd0) begin
                    rnd_nxt = hist[rd_ptr];
                end
                if (i_start) begin
                    state_nxt  = ST_RUN;
                    step_nxt   = '0;
                    period_nxt = BASE_W;
                    timer_nxt  = '0;
                    index_nxt  = 4'd0;
                end else if (browse_left) begin
                    index_nxt = index + 4'd1;
                end else if (browse_right) begin
                    index_nxt = index - 4'd1;
                end
            end

            ST_RUN: begin
                if (i_start) begin
                    // Restart leaves the history and the shown value alone.
                    step_nxt   = '0;
                    period_nxt = BASE_W;
                    timer_nxt  = '0;
                end else if (step_done) begin
                    rnd_nxt    = lfsr[3:0];
                    timer_nxt  = '0;
                    period_nxt = period + BASE_W;
                    step_nxt   = step + SW'(1);
                    if (step == LAST_STEP) begin
                        hist_we   = 1'b1;
                        wptr_nxt  = wptr + 4'd1;
                        count_nxt = (count == HIST_FULL) ? HIST_FULL : count + 5'd1;
                        index_nxt = 4'd0;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // One-hot of the next displayed value for the red LED bank.
    always_comb begin
        onehot_nxt = 16'h0001 << rnd_nxt;
    end

    // Sequencer, pointer and LFSR registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            lfsr   <= LFSR_SEED;
            timer  <= '0;
            period <= '0;
            step   <= '0;
            wptr   <= 4'd0;
            count  <= 5'd0;
            index  <= 4'd0;
        end else begin
            state  <= state_nxt;
            lfsr   <= lfsr_nxt;
            timer  <= timer_nxt;
            period <= period_nxt;
            step   <= step_nxt;
            wptr   <= wptr_nxt;
            count  <= count_nxt;
            index  <= index_nxt;
        end
    end

    // History log; the final shuffle value lands at the write pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) begin
                hist[i] <= 4'd0;
            end
        end else if (hist_we) begin
            hist[wptr] <= lfsr[3:0];
        end
    end

    // Output registers, loaded from next-state values so they stay aligned
    // with the internal state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_random_out <= 4'd0;
            o_led        <= 18'h00001;
            o_led_idx    <= 9'd0;
        end else begin
            o_random_out <= rnd_nxt;
            o_led        <= {(count_nxt == HIST_FULL), (state_nxt == ST_RUN), onehot_nxt};
            o_led_idx    <= {count_nxt, index_nxt};
        end
    end

endmodule

// File: tb/tb_lab1_random_top.sv
// Directed bench for lab1_random_top with a short shuffle (BASE=2, STEPS=4).
// A reference LFSR runs alongside the design from the same reset, and a small
// history model tracks the expected log contents.

module tb_lab1_random_top;

    localparam int BASE    = 2;
    localparam int STEPS   = 4;
    localparam int RUN_LEN = BASE * STEPS * (STEPS + 1) / 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        left;
    logic        right;
    logic [3:0]  random_out;
    logic [3:0]  index_out;
    logic [17:0] led;
    logic [8:0]  led_idx;

    int tests_run;
    int tests_failed;

    logic [15:0] ref_lfsr;
    logic [15:0] ref_prev;

    logic [3:0] hm [16];
    int         hw;
    int         hc;

    lab1_random_top #(
        .BASE_PERIOD(BASE),
        .SHUF_STEPS (STEPS)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_left      (left),
        .i_right     (right),
        .o_random_out(random_out),
        .o_index_out (index_out),
        .o_led       (led),
        .o_led_idx   (led_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR; ref_prev holds the value that was current before the last edge.
    always @(posedge clk) begin
        if (rst) ref_lfsr <= 16'hACE1;
        else     ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
        ref_prev <= ref_lfsr;
    end

    function automatic bit is_upd(input int c);
        int sum;
        sum = 0;
        for (int k = 1; k <= STEPS; k++) begin
            sum += k * BASE;
            if (c == sum) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) hm[i] = 4'd0;
        hw = 0;
        hc = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic pulse(input logic l, input logic r);
        left  = l;
        right = r;
        @(posedge clk); #1;
        left  = 1'b0;
        right = 1'b0;
        @(posedge clk); #1;
    endtask

    // Runs one full shuffle from a start pulse and checks its timing and values.
    task automatic do_shuffle(output logic [3:0] fin);
        logic [3:0]  held;
        logic [8:0]  exp_idx;
        logic [15:0] exp_oh;
        int          run_cycles;
        int          upd;
        held = 4'd0;
        upd  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_cycles = led[16] ? 1 : 0;
        for (int c = 1; c <= RUN_LEN + 3; c++) begin
            if (c == 3) left = 1'b1;
            if (c == 8) right = 1'b1;
            @(posedge clk); #1;
            left  = 1'b0;
            right = 1'b0;
            if (is_upd(c)) begin
                held = ref_prev[3:0];
                upd++;
                tests_run++;
                if (random_out !== held) begin
                    tests_failed++;
                    $display("FAIL upd_value cycle %0d: got %h expected %h", c, random_out, held);
                end
            end else if (upd > 0) begin
                tests_run++;
                if (random_out !== held) begin
                    tests_failed++;
                    $display("FAIL hold_value cycle %0d: got %h expected %h", c, random_out, held);
                end
            end
            if (c == 4) begin
                tests_run++;
                if (index_out !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL run_left_ignored: got index %0d expected 0", index_out);
                end
            end
            if (led[16]) run_cycles++;
        end
        tests_run++;
        if (run_cycles != RUN_LEN) begin
            tests_failed++;
            $display("FAIL run_length: got %0d cycles expected %0d", run_cycles, RUN_LEN);
        end
        hm[hw] = held;
        hw = (hw + 1) % 16;
        if (hc < 16) hc++;
        exp_idx = {hc[4:0], 4'd0};
        exp_oh  = 16'h0001 << held;
        tests_run++;
        if (led_idx !== exp_idx) begin
            tests_failed++;
            $display("FAIL led_idx_after_shuffle: got %b expected %b", led_idx, exp_idx);
        end
        tests_run++;
        if (led[15:0] !== exp_oh) begin
            tests_failed++;
            $display("FAIL led_onehot: got %h expected %h", led[15:0], exp_oh);
        end
        tests_run++;
        if (led[17] !== (hc == 16)) begin
            tests_failed++;
            $display("FAIL led_full: got %b expected %b", led[17], (hc == 16));
        end
        fin = held;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        repeat (10) begin
            @(posedge clk); #1;
        end
        tests_run++;
        if (random_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_random: got %h expected 0", random_out);
        end
        tests_run++;
        if (index_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_index: got %h expected 0", index_out);
        end
        tests_run++;
        if (led !== 18'h00001) begin
            tests_failed++;
            $display("FAIL reset_led: got %h expected 00001", led);
        end
        tests_run++;
        if (led_idx !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_led_idx: got %h expected 0", led_idx);
        end
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        tests_run++;
        if ({random_out, index_out, led, led_idx} !== {4'd0, 4'd0, 18'h00001, 9'd0}) begin
            tests_failed++;
            $display("FAIL empty_browse: got rnd %h idx %h led %h led_idx %h expected 0 0 00001 0",
                     random_out, index_out, led, led_idx);
        end
    endtask

    task automatic test_single();
        logic [3:0] v;
        do_shuffle(v);
        tests_run++;
        if (led_idx !== 9'b000010000) begin
            tests_failed++;
            $display("FAIL single_led_idx: got %b expected 000010000", led_idx);
        end
    endtask

    task automatic test_browse();
        logic [3:0] a, b, c;
        logic [3:0] exp_i [5];
        logic [3:0] exp_v [5];
        logic       pl    [5];
        logic       pr    [5];
        do_reset();
        do_shuffle(a);
        do_shuffle(b);
        do_shuffle(c);
        pl[0] = 1; pr[0] = 0; exp_i[0] = 4'd1; exp_v[0] = b;
        pl[1] = 1; pr[1] = 0; exp_i[1] = 4'd2; exp_v[1] = a;
        pl[2] = 1; pr[2] = 0; exp_i[2] = 4'd2; exp_v[2] = a;
        pl[3] = 0; pr[3] = 1; exp_i[3] = 4'd1; exp_v[3] = b;
        pl[4] = 1; pr[4] = 1; exp_i[4] = 4'd1; exp_v[4] = b;
        for (int i = 0; i < 5; i++) begin
            pulse(pl[i], pr[i]);
            tests_run++;
            if (index_out !== exp_i[i] || led_idx[3:0] !== exp_i[i]) begin
                tests_failed++;
                $display("FAIL browse_index step %0d: got %0d/%0d expected %0d",
                         i, index_out, led_idx[3:0], exp_i[i]);
            end
            tests_run++;
            if (random_out !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL browse_value step %0d: got %h expected %h", i, random_out, exp_v[i]);
            end
        end
    endtask

    task automatic test_full();
        logic [3:0] r [17];
        do_reset();
        for (int i = 0; i < 17; i++) do_shuffle(r[i]);
        tests_run++;
        if (led_idx[8:4] !== 5'd16 || led[17] !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_count: got count %0d full %b expected 16 1", led_idx[8:4], led[17]);
        end
        repeat (15) pulse(1'b1, 1'b0);
        tests_run++;
        if (index_out !== 4'd15 || random_out !== r[1]) begin
            tests_failed++;
            $display("FAIL full_oldest: got idx %0d val %h expected 15 %h", index_out, random_out, r[1]);
        end
        pulse(1'b1, 1'b0);
        tests_run++;
        if (index_out !== 4'd15 || random_out !== r[1]) begin
            tests_failed++;
            $display("FAIL full_left_hold: got idx %0d val %h expected 15 %h", index_out, random_out, r[1]);
        end
    endtask

    task automatic test_restart();
        logic [3:0] v;
        logic [8:0] exp_idx;
        do_reset();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        do_shuffle(v);
        repeat (25) begin
            @(posedge clk); #1;
        end
        exp_idx = 9'b000010000;
        tests_run++;
        if (led_idx !== exp_idx || led[16] !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_single_entry: got led_idx %b run %b expected %b 0", led_idx, led[16], exp_idx);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        tests_run++;
        if ({random_out, index_out, led, led_idx} !== {4'd0, 4'd0, 18'h00001, 9'd0}) begin
            tests_failed++;
            $display("FAIL mid_run_reset: got rnd %h idx %h led %h led_idx %h expected 0 0 00001 0",
                     random_out, index_out, led, led_idx);
        end
        do_shuffle(v);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        start = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        clear_model();
        test_reset();
        test_single();
        test_browse();
        test_full();
        test_restart();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
